control_unit: RTL and testbench

- Main decoder for the RV32I single-issue core. Decodes opcode/funct3/funct7 of the fetched instruction into datapath control.
- Controls cover register-file write, write-back source, data-memory write and size, ALU operand selects, ALU operation, immediate format and branch operation.
- Outputs are registered: one pipeline stage between decode and execute.

---
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// RV32I main decoder: opcode/funct3/funct7 -> datapath controls, registered one stage.
// Optional macro CU_ILLEGAL_INSN_EN adds a registered illegal_insn flag.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RUWr,
  output logic [1:0] RUDataWrSrc,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [4:0] BrOp
`ifdef CU_ILLEGAL_INSN_EN
  ,
  output logic       illegal_insn
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       ru_wr_p0;
  logic [1:0] wb_src_p0;
  logic       dm_wr_p0;
  logic [2:0] dm_ctrl_p0;
  logic       alu_a_src_p0;
  logic       alu_b_src_p0;
  logic [3:0] alu_op_p0;
  logic [2:0] imm_src_p0;
  logic [4:0] br_op_p0;

  // Only funct7[5] carries meaning in RV32I base encodings.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Stage p0: combinational decode
  always_comb begin
    ru_wr_p0     = 1'b0;
    wb_src_p0    = 2'b00;
    dm_wr_p0     = 1'b0;
    dm_ctrl_p0   = 3'b000;
    alu_a_src_p0 = 1'b0;
    alu_b_src_p0 = 1'b0;
    alu_op_p0    = 4'b0000;
    imm_src_p0   = 3'b000;
    br_op_p0     = 5'b00000;
    case (opcode)
      OP_R: begin
        ru_wr_p0  = 1'b1;
        alu_op_p0 = {funct7[5], funct3};
      end
      OP_I: begin
        ru_wr_p0     = 1'b1;
        alu_b_src_p0 = 1'b1;
        alu_op_p0    = {(funct3 == 3'b101) & funct7[5], funct3};
      end
      OP_LOAD: begin
        ru_wr_p0     = 1'b1;
        wb_src_p0    = 2'b01;
        alu_b_src_p0 = 1'b1;
        dm_ctrl_p0   = funct3;
      end
      OP_STORE: begin
        dm_wr_p0     = 1'b1;
        alu_b_src_p0 = 1'b1;
        imm_src_p0   = 3'b001;
        dm_ctrl_p0   = funct3;
      end
      OP_BRANCH: begin
        alu_a_src_p0 = 1'b1;
        alu_b_src_p0 = 1'b1;
        imm_src_p0   = 3'b010;
        br_op_p0     = {2'b01, funct3};
      end
      OP_JAL: begin
        ru_wr_p0     = 1'b1;
        wb_src_p0    = 2'b10;
        alu_a_src_p0 = 1'b1;
        alu_b_src_p0 = 1'b1;
        imm_src_p0   = 3'b100;
        br_op_p0     = 5'b10000;
      end
      OP_JALR: begin
        ru_wr_p0     = 1'b1;
        wb_src_p0    = 2'b10;
        alu_b_src_p0 = 1'b1;
        br_op_p0     = 5'b10000;
      end
      OP_LUI: begin
        ru_wr_p0     = 1'b1;
        alu_b_src_p0 = 1'b1;
        imm_src_p0   = 3'b011;
        alu_op_p0    = 4'b1111;
      end
      OP_AUIPC: begin
        ru_wr_p0     = 1'b1;
        alu_a_src_p0 = 1'b1;
        alu_b_src_p0 = 1'b1;
        imm_src_p0   = 3'b011;
      end
      default: ;
    endcase
  end

`ifdef CU_ILLEGAL_INSN_EN
  logic illegal_p0;

  always_comb begin
    illegal_p0 = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: illegal_p0 = 1'b0;
      OP_BRANCH: illegal_p0 = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_LOAD:   illegal_p0 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OP_STORE:  illegal_p0 = (funct3 > 3'b010);
      OP_JALR:   illegal_p0 = (funct3 != 3'b000);
      default:   illegal_p0 = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_insn <= 1'b0;
    else        illegal_insn <= illegal_p0;
  end
`endif

  // Stage p1: registered outputs toward execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RUWr        <= 1'b0;
      RUDataWrSrc <= 2'b00;
      DMWr        <= 1'b0;
      DMCtrl      <= 3'b000;
      ALUASrc     <= 1'b0;
      ALUBSrc     <= 1'b0;
      ALUOp       <= 4'b0000;
      ImmSrc      <= 3'b000;
      BrOp        <= 5'b00000;
    end else begin
      RUWr        <= ru_wr_p0;
      RUDataWrSrc <= wb_src_p0;
      DMWr        <= dm_wr_p0;
      DMCtrl      <= dm_ctrl_p0;
      ALUASrc     <= alu_a_src_p0;
      ALUBSrc     <= alu_b_src_p0;
      ALUOp       <= alu_op_p0;
      ImmSrc      <= imm_src_p0;
      BrOp        <= br_op_p0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset sequences, random vs. reference model.
// Honours CU_ILLEGAL_INSN_EN when the design is built with it.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RUWr;
  logic [1:0] RUDataWrSrc;
  logic       DMWr;
  logic [2:0] DMCtrl;
  logic       ALUASrc;
  logic       ALUBSrc;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;
  logic [4:0] BrOp;
  logic       ill_out;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .RUWr(RUWr), .RUDataWrSrc(RUDataWrSrc), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .BrOp(BrOp)
`ifdef CU_ILLEGAL_INSN_EN
    , .illegal_insn(ill_out)
`endif
  );

`ifndef CU_ILLEGAL_INSN_EN
  assign ill_out = 1'b0;
  localparam bit HAS_ILL = 1'b0;
`else
  localparam bit HAS_ILL = 1'b1;
`endif

  always #5 clk = ~clk;

  // Word layout: RUWr[20] Src[19:18] DMWr[17] DMCtrl[16:14] A[13] B[12] ALUOp[11:8] Imm[7:5] BrOp[4:0]
  function automatic logic [20:0] mk(input logic ru, input logic [1:0] src, input logic dmw,
                                     input logic [2:0] dmc, input logic a, input logic b,
                                     input logic [3:0] op, input logic [2:0] imm, input logic [4:0] br);
    return {ru, src, dmw, dmc, a, b, op, imm, br};
  endfunction

  logic [20:0] got;
  assign got = {RUWr, RUDataWrSrc, DMWr, DMCtrl, ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp};

  // Reference model: fixed per-opcode control word plus funct-dependent overlays.
  logic [20:0] base [logic [6:0]];

  function automatic logic [21:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [20:0] w;
    logic ill;
    if (!base.exists(op)) return {1'b1, 21'd0};
    w = base[op];
    ill = 1'b0;
    if (op == 7'b0110011) w[11:8] = {f7[5], f3};
    if (op == 7'b0010011) w[11:8] = 4'(f3) + ((f3 == 3'd5 && f7[5]) ? 4'd8 : 4'd0);
    if (op == 7'b0000011 || op == 7'b0100011) w[16:14] = f3;
    if (op == 7'b1100011) w[4:0] = 5'd8 + 5'(f3);
    if (op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3)) ill = 1'b1;
    if (op == 7'b0000011 && (f3 == 3'd3 || f3 >= 3'd6)) ill = 1'b1;
    if (op == 7'b0100011 && f3 > 3'd2) ill = 1'b1;
    if (op == 7'b1100111 && f3 != 3'd0) ill = 1'b1;
    return {ill, w};
  endfunction

  task automatic chk(input string name, input logic [20:0] act, input logic act_ill,
                     input logic [20:0] exp, input logic exp_ill);
    logic [21:0] a, e;
    a = {HAS_ILL ? act_ill : 1'b0, act};
    e = {HAS_ILL ? exp_ill : 1'b0, exp};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", name, a, e);
    end
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  logic [20:0] prev_exp;
  logic        prev_ill;
  logic [6:0]  ops [9];

  initial begin
    base[7'b0110011] = mk(1, 2'b00, 0, 3'b000, 0, 0, 4'h0, 3'b000, 5'b00000);
    base[7'b0010011] = mk(1, 2'b00, 0, 3'b000, 0, 1, 4'h0, 3'b000, 5'b00000);
    base[7'b0000011] = mk(1, 2'b01, 0, 3'b000, 0, 1, 4'h0, 3'b000, 5'b00000);
    base[7'b0100011] = mk(0, 2'b00, 1, 3'b000, 0, 1, 4'h0, 3'b001, 5'b00000);
    base[7'b1100011] = mk(0, 2'b00, 0, 3'b000, 1, 1, 4'h0, 3'b010, 5'b00000);
    base[7'b1101111] = mk(1, 2'b10, 0, 3'b000, 1, 1, 4'h0, 3'b100, 5'b10000);
    base[7'b1100111] = mk(1, 2'b10, 0, 3'b000, 0, 1, 4'h0, 3'b000, 5'b10000);
    base[7'b0110111] = mk(1, 2'b00, 0, 3'b000, 0, 1, 4'hF, 3'b011, 5'b00000);
    base[7'b0010111] = mk(1, 2'b00, 0, 3'b000, 1, 1, 4'h0, 3'b011, 5'b00000);
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    vecs.push_back('{"sub",    7'b0110011, 3'b000, 7'b0100000, mk(1,2'b00,0,3'b000,0,0,4'b1000,3'b000,5'b00000), 0});
    vecs.push_back('{"slt_f7", 7'b0110011, 3'b010, 7'b1111111, mk(1,2'b00,0,3'b000,0,0,4'b1010,3'b000,5'b00000), 0});
    vecs.push_back('{"addi",   7'b0010011, 3'b000, 7'b0100000, mk(1,2'b00,0,3'b000,0,1,4'b0000,3'b000,5'b00000), 0});
    vecs.push_back('{"slli",   7'b0010011, 3'b001, 7'b0100000, mk(1,2'b00,0,3'b000,0,1,4'b0001,3'b000,5'b00000), 0});
    vecs.push_back('{"srai",   7'b0010011, 3'b101, 7'b0100000, mk(1,2'b00,0,3'b000,0,1,4'b1101,3'b000,5'b00000), 0});
    vecs.push_back('{"srli",   7'b0010011, 3'b101, 7'b0000000, mk(1,2'b00,0,3'b000,0,1,4'b0101,3'b000,5'b00000), 0});
    vecs.push_back('{"lw",     7'b0000011, 3'b010, 7'b0000000, mk(1,2'b01,0,3'b010,0,1,4'b0000,3'b000,5'b00000), 0});
    vecs.push_back('{"lbu",    7'b0000011, 3'b100, 7'b0000000, mk(1,2'b01,0,3'b100,0,1,4'b0000,3'b000,5'b00000), 0});
    vecs.push_back('{"ld_rsv", 7'b0000011, 3'b011, 7'b0000000, mk(1,2'b01,0,3'b011,0,1,4'b0000,3'b000,5'b00000), 1});
    vecs.push_back('{"sw",     7'b0100011, 3'b010, 7'b0000000, mk(0,2'b00,1,3'b010,0,1,4'b0000,3'b001,5'b00000), 0});
    vecs.push_back('{"st_rsv", 7'b0100011, 3'b011, 7'b0000000, mk(0,2'b00,1,3'b011,0,1,4'b0000,3'b001,5'b00000), 1});
    vecs.push_back('{"beq",    7'b1100011, 3'b000, 7'b0000000, mk(0,2'b00,0,3'b000,1,1,4'b0000,3'b010,5'b01000), 0});
    vecs.push_back('{"bgeu",   7'b1100011, 3'b111, 7'b0000000, mk(0,2'b00,0,3'b000,1,1,4'b0000,3'b010,5'b01111), 0});
    vecs.push_back('{"br_rsv", 7'b1100011, 3'b010, 7'b0000000, mk(0,2'b00,0,3'b000,1,1,4'b0000,3'b010,5'b01010), 1});
    vecs.push_back('{"jal",    7'b1101111, 3'b000, 7'b0000000, mk(1,2'b10,0,3'b000,1,1,4'b0000,3'b100,5'b10000), 0});
    vecs.push_back('{"jalr",   7'b1100111, 3'b000, 7'b0000000, mk(1,2'b10,0,3'b000,0,1,4'b0000,3'b000,5'b10000), 0});
    vecs.push_back('{"jalr_f3",7'b1100111, 3'b001, 7'b0000000, mk(1,2'b10,0,3'b000,0,1,4'b0000,3'b000,5'b10000), 1});
    vecs.push_back('{"lui",    7'b0110111, 3'b000, 7'b0000000, mk(1,2'b00,0,3'b000,0,1,4'b1111,3'b011,5'b00000), 0});
    vecs.push_back('{"auipc",  7'b0010111, 3'b000, 7'b0000000, mk(1,2'b00,0,3'b000,1,1,4'b0000,3'b011,5'b00000), 0});
    vecs.push_back('{"bad_op", 7'b1111111, 3'b000, 7'b0000000, 21'd0, 1});
    vecs.push_back('{"add2",   7'b0110011, 3'b000, 7'b0000000, mk(1,2'b00,0,3'b000,0,0,4'b0000,3'b000,5'b00000), 0});

    // Power-on reset with an R-type applied
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
    @(posedge clk); #1;
    chk("por_zero", got, ill_out, 21'd0, 1'b0);
    rst_n = 1'b1; funct7 = 7'b0000000;
    @(posedge clk); #1;
    chk("add_after_rst", got, ill_out, mk(1,2'b00,0,3'b000,0,0,4'b0000,3'b000,5'b00000), 1'b0);

    // Asynchronous assert mid-cycle, synchronous release
    #2 rst_n = 1'b0;
    #1 chk("async_rst", got, ill_out, 21'd0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk("rel_hold", got, ill_out, 21'd0, 1'b0);
    @(posedge clk); #1;
    chk("add_rel", got, ill_out, mk(1,2'b00,0,3'b000,0,0,4'b0000,3'b000,5'b00000), 1'b0);
    prev_exp = mk(1,2'b00,0,3'b000,0,0,4'b0000,3'b000,5'b00000);
    prev_ill = 1'b0;

    // Directed table: output holds until the edge, then takes the new decode
    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      @(negedge clk);
      chk({vecs[i].name, "_hold"}, got, ill_out, prev_exp, prev_ill);
      @(posedge clk); #1;
      chk(vecs[i].name, got, ill_out, vecs[i].exp, vecs[i].ill);
      prev_exp = vecs[i].exp;
      prev_ill = vecs[i].ill;
    end

    // Random stream against the reference model
    for (int k = 0; k < 400; k++) begin
      logic [21:0] m;
      int sel;
      sel = int'($urandom_range(0, 10));
      opcode = (sel >= 9) ? 7'($urandom) : ops[sel];
      funct3 = 3'($urandom);
      funct7 = 7'($urandom);
      m = model(opcode, funct3, funct7);
      @(posedge clk); #1;
      chk("rand", got, ill_out, m[20:0], m[21]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
